spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
- SPI mode-0 target (slave): the far end of the existing spi_controller master.
- Lets an external SPI master (a second board, or the bench) exchange bytes with the core via MMIO.
- Oversamples the external SCK/CS_n/MOSI in the clk domain and drives MISO.
- Presents byte FIFOs toward the Memory_Controller, using the same rd/wr/avail/empty/full style as the SPI master block.

Parameters:
DEPTH, 8, entries in each of the RX and TX FIFOs (power of 2, ≥2)
IDLE_BYTE, 8'hFF, byte shifted out when the TX FIFO is empty at a byte boundary

Ports:
clk  in  1  system clock (clk_50M domain)
rst_n  in  1  asynchronous active-low reset
sck_in  in  1  external SPI clock (asynchronous, ≤ clk/8)
cs_n_in  in  1  external chip select, active low (asynchronous)
mosi_in  in  1  external master-out data
miso_out  out  1  target-out data
miso_oe  out  1  MISO output enable (high only while selected)
rd  in  1  pop RX FIFO head
wr  in  1  push din into TX FIFO
din  in  8  TX byte from core
dout  out  8  RX FIFO head (first-word fall-through)
rx_avail  out  1  RX FIFO non-empty
rx_full  out  1  RX FIFO full
tx_empty  out  1  TX FIFO empty
tx_full  out  1  TX FIFO full
overrun  out  1  sticky: RX byte dropped because RX FIFO was full
underrun  out  1  sticky: IDLE_BYTE substituted because TX FIFO was empty
clr_err  in  1  clears overrun/underrun (pulse)

Behaviour:

Reset (async assert, sync release):
- Both FIFOs empty.
- State IDLE.
- miso_out=1, miso_oe=0, dout=8'h00.
- rx_avail=0, rx_full=0, tx_empty=1, tx_full=0, overrun=0, underrun=0.
- Synchronizer flops preset to sck=0, cs_n=1, mosi=0.

Input synchronization:
- sck_in, cs_n_in and mosi_in each pass through 2 flops.
- A third flop on sck and cs_n gives one-cycle edge pulses: sck_rise, sck_fall, cs_fall, cs_rise.

State machine (IDLE, LOAD, SHIFT):
- IDLE: on cs_fall → LOAD.
- LOAD (1 cycle):
  - If TX non-empty, pop TX into shift_tx; otherwise shift_tx = IDLE_BYTE and set underrun.
  - Set bit_cnt=0, miso_oe=1, miso_out=shift_tx[7] (MSB first).
  - Go to SHIFT.
- SHIFT:
  - On sck_rise: shift_rx = {shift_rx[6:0], mosi_sync}, bit_cnt++.
  - On sck_rise with bit_cnt==7: push the completed byte to RX; if RX is full, drop the byte and set overrun.
  - On sck_fall with bit_cnt 1..7: miso_out = next bit of shift_tx.
  - On sck_fall with bit_cnt==0 after a completed byte: reload shift_tx (pop TX, or IDLE_BYTE plus underrun), present its MSB, continue SHIFT.
- Any state, on cs_rise:
  - Go to IDLE, miso_oe=0, bit_cnt=0.
  - A partial RX byte is discarded; no push.
  - A TX byte already loaded is consumed and not restored.
- cs_fall during SHIFT is impossible; if one is seen anyway, treat it as cs_rise followed by cs_fall (restart via LOAD).

Latency:
- RX byte visible on rx_avail/dout 2 clk after the 8th synchronized sck rising edge.
- wr → tx_empty=0 on the next clk edge.

FIFOs:
- Both are synchronous, first-word fall-through, with a count of log2(DEPTH)+1 bits.
- RX: rd while empty is ignored. Hardware push and rd in the same cycle both succeed.
  - When full, the simultaneous pop frees the slot, so there is no overrun.
- TX: wr while full is ignored, with no flag. wr and LOAD/reload pop in the same cycle both succeed, including when full.
- Pointers wrap modulo DEPTH.

Error flags:
- clr_err clears overrun and underrun.
- If clr_err and a new error coincide in the same cycle, the new error wins (flag stays 1).

Decomposition:
- Package spi_target_pkg:
  - state_t enum {IDLE, LOAD, SHIFT}
  - localparam BYTE_W=8
  - localparam SYNC_STAGES=2
- Sub-module sync_fifo #(WIDTH, DEPTH): push, pop, din, dout, empty, full.
  - Instantiated twice (RX and TX).
- Synchronizer and edge detect stay inline.

Test Plan:
1. Core writes 8'hA5 to TX; master asserts CS, clocks 8 bits with MOSI=8'h3C at clk/16 → MISO shows 1,0,1,0,0,1,0,1; rx_avail=1, dout=8'h3C; rd pops → rx_avail=0.
2. TX empty, master transfers 2 bytes 8'h01, 8'h02 → MISO 8'hFF twice, underrun=1; clr_err → underrun=0.
3. Fill RX with DEPTH=8 bytes, master sends a 9th byte 8'h99 → rx_full=1, overrun=1, FIFO head still first byte. Repeat with rd asserted on the push cycle → no overrun, 8'h99 becomes the last entry.
4. Master deasserts CS after 5 bits of 8'hF0 → no RX push, miso_oe=0, state IDLE. Next full transfer of 8'h55 → dout=8'h55.
5. Assert rst_n=0 mid-byte with TX holding 3 bytes → all outputs at reset values immediately, without waiting for a clk edge; tx_empty=1.
6. wr 9 bytes 8'h10..8'h18 into TX → tx_full after 8; 8'h18 dropped; master reads 8 bytes → 8'h10..8'h17 in order.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
//   state_t     : byte-engine state (IDLE, LOAD, SHIFT)
//   BYTE_W      : width of one SPI byte
//   SYNC_STAGES : flops used to bring each external SPI pin into the clk domain
package spi_target_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  localparam int BYTE_W      = 8;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_target_fifo.sv
// Synchronous first-word fall-through FIFO, used for the RX and TX byte queues.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail (ignored when full unless popping too)
//   pop        : drop the head entry (ignored when empty)
//   dout       : current head entry, reads as zero while empty
//   empty/full : occupancy status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: an external master exchanges bytes with the core through
// an RX FIFO (bytes received on MOSI) and a TX FIFO (bytes sent on MISO).
//   clk, rst_n                : system clock, asynchronous active-low reset
//   sck_in, cs_n_in, mosi_in  : external SPI pins, asynchronous to clk
//   miso_out, miso_oe         : MISO data and its output enable (high while selected)
//   rd, dout, rx_avail, rx_full   : core side of the RX FIFO (dout is the head)
//   wr, din, tx_empty, tx_full    : core side of the TX FIFO
//   overrun, underrun, clr_err    : sticky error flags and their clear pulse
module spi_target
  import spi_target_pkg::*;
#(
  parameter int                DEPTH     = 8,
  parameter logic [BYTE_W-1:0] IDLE_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck_in,
  input  logic              cs_n_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              miso_oe,
  input  logic              rd,
  input  logic              wr,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              rx_avail,
  output logic              rx_full,
  output logic              tx_empty,
  output logic              tx_full,
  output logic              overrun,
  output logic              underrun,
  input  logic              clr_err
);

  localparam int              BIT_W    = $clog2(BYTE_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_W - 1);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_fall;
  logic                   cs_rise;

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic              byte_done;
  logic [BYTE_W-1:0] shift_tx;
  logic [BYTE_W-1:0] shift_rx;

  logic [BYTE_W-1:0] tx_dout;
  logic [BYTE_W-1:0] next_tx;
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_empty;
  logic              rx_push;
  logic              tx_pop;
  logic              reload;
  logic              do_load;
  logic              overrun_evt;
  logic              underrun_evt;

  // Synchronizers preset to the idle bus (SCK low, CS deasserted) so reset
  // release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s && !sck_d;
  assign sck_fall = !sck_s && sck_d;
  assign cs_fall  = !cs_s && cs_d;
  assign cs_rise  = cs_s && !cs_d;

  // A byte boundary is the first SCK fall after the 8th rise; byte_done tells
  // it apart from the bit_cnt==0 state right after LOAD.
  assign reload       = (state == SHIFT) && sck_fall && (bit_cnt == '0) && byte_done;
  assign do_load      = !cs_rise && !cs_fall && ((state == LOAD) || reload);
  assign next_tx      = tx_empty ? IDLE_BYTE : tx_dout;
  assign tx_pop       = do_load && !tx_empty;
  assign underrun_evt = do_load && tx_empty;

  assign rx_byte     = {shift_rx[BYTE_W-2:0], mosi_s};
  assign rx_push     = !cs_rise && !cs_fall && (state == SHIFT) && sck_rise
                       && (bit_cnt == LAST_BIT);
  assign overrun_evt = rx_push && rx_full && !rd;
  assign rx_avail    = !rx_empty;

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rd),
    .din   (rx_byte),
    .dout  (dout),
    .empty (rx_empty),
    .full  (rx_full)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr),
    .pop   (tx_pop),
    .din   (din),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full)
  );

  // Byte engine. CS edges take priority over everything else; a CS fall seen
  // mid-transfer simply restarts through LOAD. A new error outranks clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      shift_tx  <= '0;
      shift_rx  <= '0;
      miso_out  <= 1'b1;
      miso_oe   <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      overrun  <= (overrun && !clr_err) || overrun_evt;
      underrun <= (underrun && !clr_err) || underrun_evt;

      if (cs_rise) begin
        state     <= IDLE;
        miso_oe   <= 1'b0;
        miso_out  <= 1'b1;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else if (cs_fall) begin
        state     <= LOAD;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            shift_tx  <= next_tx;
            miso_out  <= next_tx[BYTE_W-1];
            miso_oe   <= 1'b1;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            state     <= SHIFT;
          end
          SHIFT: begin
            if (sck_rise) begin
              shift_rx  <= rx_byte;
              bit_cnt   <= bit_cnt + BIT_W'(1);
              byte_done <= (bit_cnt == LAST_BIT);
            end else if (sck_fall) begin
              if (bit_cnt != '0) begin
                miso_out <= shift_tx[LAST_BIT - bit_cnt];
              end else if (byte_done) begin
                shift_tx  <= next_tx;
                miso_out  <= next_tx[BYTE_W-1];
                byte_done <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a table of single-byte transfers plus
// hand-written sequences for underrun, overrun, aborted bytes, async reset and
// TX FIFO fill. The bench plays the SPI master at SCK = clk/16.
module tb_spi_target;

  typedef struct {
    logic       has_tx;
    logic [7:0] tx_byte;
    logic [7:0] mosi_byte;
    logic [7:0] exp_miso;
    logic       exp_underrun;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck_in;
  logic       cs_n_in;
  logic       mosi_in;
  logic       miso_out;
  logic       miso_oe;
  logic       rd;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rx_avail;
  logic       rx_full;
  logic       tx_empty;
  logic       tx_full;
  logic       overrun;
  logic       underrun;
  logic       clr_err;

  int errors = 0;
  int checks = 0;

  vec_t vecs [5];

  spi_target #(.DEPTH(8), .IDLE_BYTE(8'hFF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck_in   (sck_in),
    .cs_n_in  (cs_n_in),
    .mosi_in  (mosi_in),
    .miso_out (miso_out),
    .miso_oe  (miso_oe),
    .rd       (rd),
    .wr       (wr),
    .din      (din),
    .dout     (dout),
    .rx_avail (rx_avail),
    .rx_full  (rx_full),
    .tx_empty (tx_empty),
    .tx_full  (tx_full),
    .overrun  (overrun),
    .underrun (underrun),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  // Hard time limit so a stuck run still ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic core_write(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  task automatic core_read();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic spi_select();
    sck_in  = 1'b0;
    cs_n_in = 1'b0;
    wait_clk(8);
  endtask

  task automatic spi_deselect();
    sck_in = 1'b0;
    wait_clk(8);
    cs_n_in = 1'b1;
    wait_clk(8);
  endtask

  // Clocks nbits MSB-first; MISO is sampled just before each rising edge.
  // SCK is left high after the last bit. With pop_last, rd is pulsed in the
  // cycle the target pushes the final received bit.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit pop_last,
                          output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      sck_in  = 1'b0;
      mosi_in = mo[7-i];
      wait_clk(8);
      mi = {mi[6:0], miso_out};
      sck_in = 1'b1;
      if (pop_last && (i == nbits - 1)) begin
        wait_clk(2);
        rd = 1'b1;
        wait_clk(1);
        rd = 1'b0;
        wait_clk(5);
      end else begin
        wait_clk(8);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, " miso_out"}, miso_out, 1);
    checkOutput({tag, " miso_oe"},  miso_oe,  0);
    checkOutput({tag, " dout"},     dout,     0);
    checkOutput({tag, " rx_avail"}, rx_avail, 0);
    checkOutput({tag, " rx_full"},  rx_full,  0);
    checkOutput({tag, " tx_empty"}, tx_empty, 1);
    checkOutput({tag, " tx_full"},  tx_full,  0);
    checkOutput({tag, " overrun"},  overrun,  0);
    checkOutput({tag, " underrun"}, underrun, 0);
  endtask

  // One table row: optional TX byte, a single-byte frame, then drain and clear.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [7:0] got;
    string      tag;
    tag = $sformatf("vec%0d", idx);
    if (v.has_tx) begin
      core_write(v.tx_byte);
      checkOutput({tag, " tx_empty after wr"}, tx_empty, 0);
    end
    spi_select();
    checkOutput({tag, " miso_oe selected"}, miso_oe, 1);
    spi_xfer(v.mosi_byte, 8, 1'b0, got);
    checkOutput({tag, " miso byte"}, got, v.exp_miso);
    checkOutput({tag, " rx_avail"}, rx_avail, 1);
    checkOutput({tag, " dout"}, dout, v.mosi_byte);
    checkOutput({tag, " underrun"}, underrun, v.exp_underrun);
    spi_deselect();
    checkOutput({tag, " miso_oe released"}, miso_oe, 0);
    core_read();
    checkOutput({tag, " rx_avail after rd"}, rx_avail, 0);
    pulse_clr();
    checkOutput({tag, " underrun cleared"}, underrun, 0);
  endtask

  initial begin
    logic [7:0] got;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 8'h81, 8'hFF, 1'b1};
    vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h80, 1'b0};

    rst_n   = 1'b0;
    sck_in  = 1'b0;
    cs_n_in = 1'b1;
    mosi_in = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    din     = 8'h00;
    clr_err = 1'b0;
    wait_clk(3);
    check_reset_state("reset");
    rst_n = 1'b1;
    wait_clk(4);

    $display("[TB] table-driven single-byte transfers");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("[TB] empty TX: two-byte frame");
    spi_select();
    spi_xfer(8'h01, 8, 1'b0, got);
    checkOutput("t2 miso byte0", got, 8'hFF);
    checkOutput("t2 underrun", underrun, 1);
    spi_xfer(8'h02, 8, 1'b0, got);
    checkOutput("t2 miso byte1", got, 8'hFF);
    spi_deselect();
    checkOutput("t2 rx head0", dout, 8'h01);
    core_read();
    checkOutput("t2 rx head1", dout, 8'h02);
    core_read();
    checkOutput("t2 rx drained", rx_avail, 0);
    pulse_clr();
    checkOutput("t2 underrun cleared", underrun, 0);

    $display("[TB] RX fill and overrun");
    spi_select();
    for (int i = 0; i < 8; i++) begin
      spi_xfer(8'h60 + 8'(i), 8, 1'b0, got);
    end
    checkOutput("t3 rx_full", rx_full, 1);
    checkOutput("t3 no overrun yet", overrun, 0);
    spi_xfer(8'h99, 8, 1'b0, got);
    checkOutput("t3 overrun", overrun, 1);
    checkOutput("t3 rx_full kept", rx_full, 1);
    checkOutput("t3 head kept", dout, 8'h60);
    spi_deselect();
    pulse_clr();
    checkOutput("t3 overrun cleared", overrun, 0);
    spi_select();
    spi_xfer(8'h99, 8, 1'b1, got);
    checkOutput("t3 pop+push no overrun", overrun, 0);
    checkOutput("t3 pop+push still full", rx_full, 1);
    spi_deselect();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t3 drain%0d", i), dout,
                  (i == 7) ? 8'h99 : (8'h61 + 8'(i)));
      core_read();
    end
    checkOutput("t3 drained", rx_avail, 0);
    pulse_clr();

    $display("[TB] aborted partial byte");
    spi_select();
    checkOutput("t4 miso_oe selected", miso_oe, 1);
    spi_xfer(8'hF0, 5, 1'b0, got);
    spi_deselect();
    checkOutput("t4 no rx push", rx_avail, 0);
    checkOutput("t4 miso_oe released", miso_oe, 0);
    spi_select();
    spi_xfer(8'h55, 8, 1'b0, got);
    spi_deselect();
    checkOutput("t4 rx_avail", rx_avail, 1);
    checkOutput("t4 dout", dout, 8'h55);
    core_read();
    pulse_clr();

    $display("[TB] asynchronous reset mid-byte");
    core_write(8'h11);
    core_write(8'h22);
    core_write(8'h33);
    spi_select();
    spi_xfer(8'hAA, 3, 1'b0, got);
    checkOutput("t5 tx before reset", tx_empty, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("t5");
    cs_n_in = 1'b1;
    sck_in  = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);

    $display("[TB] TX fill, drop when full, ordered readout");
    for (int i = 0; i < 8; i++) begin
      core_write(8'h10 + 8'(i));
    end
    checkOutput("t6 tx_full", tx_full, 1);
    core_write(8'h18);
    checkOutput("t6 tx_full after extra wr", tx_full, 1);
    spi_select();
    for (int i = 0; i < 8; i++) begin
      spi_xfer(8'hC0 + 8'(i), 8, 1'b0, got);
      checkOutput($sformatf("t6 miso%0d", i), got, 8'h10 + 8'(i));
    end
    spi_deselect();
    checkOutput("t6 tx_empty", tx_empty, 1);
    checkOutput("t6 rx_full", rx_full, 1);
    checkOutput("t6 no overrun", overrun, 0);
    for (int i = 0; i < 8; i++) begin
      core_read();
    end
    checkOutput("t6 rx drained", rx_avail, 0);
    pulse_clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
